// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 command codes, sequencer state encoding and CP0 register indices.
package cp0_pkg;

    typedef enum logic [2:0] {
        CP0OP_NONE = 3'b000,
        CP0OP_MFC0 = 3'b001,
        CP0OP_MTC0 = 3'b010,
        CP0OP_TRAP = 3'b011,
        CP0OP_ERET = 3'b100
    } cp0op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        ERET  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [29:0] EXC_VEC_DEFAULT = 30'h0000_0010;

    localparam logic [4:0] CP0_STATUS_CS  = 5'd12;
    localparam logic [2:0] CP0_STATUS_SEL = 3'd0;
    localparam logic [4:0] CP0_CAUSE_CS   = 5'd13;
    localparam logic [2:0] CP0_CAUSE_SEL  = 3'd0;
    localparam logic [4:0] CP0_EPC_CS     = 5'd14;
    localparam logic [2:0] CP0_EPC_SEL    = 3'd0;

endpackage

// File: rtl/cp0_irq_sync.sv
// cp0_irq_sync: per-line 2-flop synchronizer plus rising-edge detect, one-cycle set pulses out.
module cp0_irq_sync
    import cp0_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    output logic [N-1:0] rise
);

    logic [N-1:0] s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: WB-boundary exception/interrupt sequencer producing CP0 write commands, flush and fetch redirect.
// The interrupt path exists only when CP0_IRQ_EN is defined.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ      = 6,
    parameter logic [29:0] EXC_VEC      = EXC_VEC_DEFAULT,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid,
    input  logic [2:0]         wb_cp0op,
    input  logic [29:0]        wb_pc,
    input  logic [4:0]         wb_cs,
    input  logic [2:0]         wb_sel,
    input  logic [31:0]        wb_busB,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               status_ie,
    input  logic               status_exl,
    input  logic [31:0]        cp0_epc,
    output logic [2:0]         wr_cp0op,
    output logic [4:0]         wr_cs,
    output logic [2:0]         wr_sel,
    output logic [31:0]        wr_data,
    output logic               flush,
    output logic               redirect_valid,
    output logic [29:0]        redirect_pc,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam int CW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    cp0op_e        op_n;
    logic [4:0]    cs_n;
    logic [2:0]    sel_n;
    logic [31:0]   data_n;
    logic [29:0]   rpc_n;
    logic          flush_n, rv_n, irq_req, take_irq, unused_bits;

`ifdef CP0_IRQ_EN
    logic [NUM_IRQ-1:0] rise;

    cp0_irq_sync #(.N(NUM_IRQ)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .rise   (rise)
    );

    // a new edge on the bit being taken must survive the take-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_pending <= '0;
        else irq_pending <= (irq_pending & ~(take_irq ? irq_pending & -irq_pending : '0)) | rise;
    end

    assign irq_req     = status_ie & ~status_exl & (|irq_pending);
    assign unused_bits = ^cp0_epc[1:0];
`else
    assign irq_pending = '0;
    assign irq_req     = 1'b0;
    assign unused_bits = ^{cp0_epc[1:0], irq_in, status_ie, status_exl};
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = CP0OP_NONE;
        cs_n     = wr_cs;
        sel_n    = wr_sel;
        data_n   = wr_data;
        rpc_n    = redirect_pc;
        flush_n  = 1'b0;
        rv_n     = 1'b0;
        take_irq = 1'b0;
        unique case (state)
            IDLE: begin
                take_irq = wb_valid && irq_req && (wb_cp0op == CP0OP_NONE || wb_cp0op == CP0OP_MFC0);
                if (take_irq || (wb_valid && wb_cp0op == CP0OP_TRAP)) begin
                    state_n = TRAP;
                    op_n    = CP0OP_TRAP;
                    cs_n    = CP0_EPC_CS;
                    sel_n   = CP0_EPC_SEL;
                    data_n  = {take_irq ? wb_pc + 30'd1 : wb_pc, 2'b00};
                    flush_n = 1'b1;
                end else if (wb_valid && wb_cp0op == CP0OP_ERET) begin
                    state_n = ERET;
                    op_n    = CP0OP_ERET;
                    rv_n    = 1'b1;
                    rpc_n   = cp0_epc[31:2];
                    flush_n = 1'b1;
                end else if (wb_valid && wb_cp0op == CP0OP_MTC0) begin
                    op_n   = CP0OP_MTC0;
                    cs_n   = wb_cs;
                    sel_n  = wb_sel;
                    data_n = wb_busB;
                end
            end
            TRAP: begin
                state_n = DRAIN;
                cnt_n   = CW'(DRAIN_CYCLES);
                rv_n    = 1'b1;
                rpc_n   = EXC_VEC;
                flush_n = 1'b1;
            end
            // the ERET cycle already carried the redirect, so one drain cycle is spent on the way out
            ERET: begin
                state_n = DRAIN_CYCLES == 0 ? IDLE : DRAIN;
                cnt_n   = CW'(DRAIN_CYCLES - 1);
                flush_n = DRAIN_CYCLES != 0;
            end
            DRAIN: begin
                state_n = cnt == '0 ? IDLE : DRAIN;
                cnt_n   = cnt - CW'(1);
                flush_n = cnt != '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            wr_cp0op       <= '0;
            wr_cs          <= '0;
            wr_sel         <= '0;
            wr_data        <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            wr_cp0op       <= op_n;
            wr_cs          <= cs_n;
            wr_sel         <= sel_n;
            wr_data        <= data_n;
            flush          <= flush_n;
            redirect_valid <= rv_n;
            redirect_pc    <= rpc_n;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: scoreboard bench for cp0_exc_ctrl; the reference model schedules expected events per cycle.
// Follows CP0_IRQ_EN the same way as the design build.
module tb_cp0_exc_ctrl;

    localparam int          NUM_IRQ = 6;
    localparam logic [29:0] EXC_VEC = 30'h0000_0010;
    localparam int          DRAIN   = 2;
`ifdef CP0_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wb_valid = 1'b0;
    logic [2:0]         wb_cp0op = '0;
    logic [29:0]        wb_pc = '0;
    logic [4:0]         wb_cs = '0;
    logic [2:0]         wb_sel = '0;
    logic [31:0]        wb_busB = '0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic               status_ie = 1'b0;
    logic               status_exl = 1'b0;
    logic [31:0]        cp0_epc = '0;
    logic [2:0]         wr_cp0op;
    logic [4:0]         wr_cs;
    logic [2:0]         wr_sel;
    logic [31:0]        wr_data;
    logic               flush;
    logic               redirect_valid;
    logic [29:0]        redirect_pc;
    logic [NUM_IRQ-1:0] irq_pending;

    cp0_exc_ctrl #(.NUM_IRQ(NUM_IRQ), .EXC_VEC(EXC_VEC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_cp0op       (wb_cp0op),
        .wb_pc          (wb_pc),
        .wb_cs          (wb_cs),
        .wb_sel         (wb_sel),
        .wb_busB        (wb_busB),
        .irq_in         (irq_in),
        .status_ie      (status_ie),
        .status_exl     (status_exl),
        .cp0_epc        (cp0_epc),
        .wr_cp0op       (wr_cp0op),
        .wr_cs          (wr_cs),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irq_pending    (irq_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [2:0]  op;
        bit          chk_cs, chk_data, rv;
        logic [4:0]  cs;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [29:0] rpc;
    } ev_t;

    ev_t                exp_q[$];
    logic [NUM_IRQ-1:0] hist[int];
    int                 busy_until = 0, flush_from = 0, flush_until = -1, hist_base = 0;
    logic [NUM_IRQ-1:0] pend_cur = '0, pend_nxt = '0, irq_v = '0;
    bit                 ie_v, exl_v;
    int                 n_cmp = 0, n_bad = 0;

    function automatic logic [NUM_IRQ-1:0] hist_at(int c);
        return (c < hist_base || !hist.exists(c)) ? '0 : hist[c];
    endfunction

    function automatic void push_ev(int c, logic [2:0] op, bit chk_cs, bit chk_data, bit rv,
                                     logic [4:0] cs, logic [2:0] sel, logic [31:0] data, logic [29:0] rpc);
        ev_t e;
        e.cyc = c; e.op = op; e.chk_cs = chk_cs; e.chk_data = chk_data; e.rv = rv;
        e.cs = cs; e.sel = sel; e.data = data; e.rpc = rpc;
        exp_q.push_back(e);
    endfunction

    // trap: EPC write next cycle, vector redirect the cycle after, then DRAIN extra flush cycles
    function automatic void sched_trap(int n, logic [29:0] epc_word);
        push_ev(n + 1, 3'b011, 1'b0, 1'b1, 1'b0, '0, '0, {epc_word, 2'b00}, '0);
        push_ev(n + 2, 3'b000, 1'b0, 1'b0, 1'b1, '0, '0, '0, EXC_VEC);
        flush_from  = n + 1;
        flush_until = n + 2 + DRAIN;
        busy_until  = n + 3 + DRAIN;
    endfunction

    task automatic step(bit v, logic [2:0] op, logic [29:0] pc, logic [4:0] cs, logic [2:0] sel,
                        logic [31:0] b, logic [31:0] epc);
        int c;
        logic [NUM_IRQ-1:0] clr, rise;
        c = cyc;
        wb_valid = v; wb_cp0op = op; wb_pc = pc; wb_cs = cs; wb_sel = sel; wb_busB = b;
        irq_in = irq_v; status_ie = ie_v; status_exl = exl_v; cp0_epc = epc;
        pend_cur = pend_nxt;
        hist[c] = irq_v;
        rise = hist_at(c - 2) & ~hist_at(c - 3);
        clr = '0;
        if (v && c >= busy_until) begin
            if (op == 3'b011) sched_trap(c, pc);
            else if (op == 3'b100) begin
                push_ev(c + 1, 3'b100, 1'b0, 1'b0, 1'b1, '0, '0, '0, epc[31:2]);
                flush_from  = c + 1;
                flush_until = c + 1 + DRAIN;
                busy_until  = c + 2 + DRAIN;
            end else if (op == 3'b010) push_ev(c + 1, 3'b010, 1'b1, 1'b1, 1'b0, cs, sel, b, '0);
            else if (op <= 3'b001 && ie_v && !exl_v && pend_cur != '0) begin
                sched_trap(c, pc + 30'd1);
                for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend_cur[i]) clr = NUM_IRQ'(1) << i;
            end
        end
        pend_nxt = IRQ_EN ? ((pend_cur & ~clr) | rise) : '0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 3'b000, '0, '0, '0, '0, '0);
    endtask

    task automatic nops(int n, logic [29:0] pc);
        repeat (n) step(1'b1, 3'b000, pc, '0, '0, '0, '0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        hist_base = cyc;
        busy_until = cyc;
        pend_cur = '0;
        pend_nxt = '0;
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        wb_valid = 1'b0;
        exp_q.delete();
        flush_from = 0;
        flush_until = -1;
        pend_cur = '0;
        pend_nxt = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        release_reset();
    endtask

    function automatic logic [2:0] pick_op();
        int r = $urandom_range(0, 9);
        return r < 4 ? 3'b000 : r == 4 ? 3'b001 : r < 7 ? 3'b010 : r == 7 ? 3'b011 :
               r == 8 ? 3'b100 : 3'($urandom_range(5, 7));
    endfunction

    ev_t me;
    bit  mok, ef;

    always @(negedge clk) begin
        ef = cyc >= flush_from && cyc <= flush_until;
        n_cmp++;
        if (flush !== ef) begin
            n_bad++;
            $display("FAIL flush cyc=%0d got=%0b exp=%0b", cyc, flush, ef);
        end
        n_cmp++;
        if (irq_pending !== pend_cur) begin
            n_bad++;
            $display("FAIL irq_pending cyc=%0d got=%b exp=%b", cyc, irq_pending, pend_cur);
        end
        if (wr_cp0op != 3'b000 || redirect_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got op=%0h rv=%0b rpc=%0h data=%0h exp none",
                         cyc, wr_cp0op, redirect_valid, redirect_pc, wr_data);
            end else begin
                me = exp_q.pop_front();
                mok = me.cyc == cyc && wr_cp0op == me.op && redirect_valid == me.rv &&
                      (!me.rv || redirect_pc == me.rpc) && (!me.chk_data || wr_data == me.data) &&
                      (!me.chk_cs || (wr_cs == me.cs && wr_sel == me.sel));
                if (!mok) begin
                    n_bad++;
                    $display("FAIL event cyc=%0d got op=%0h rv=%0b rpc=%0h data=%0h cs=%0d sel=%0d exp cyc=%0d op=%0h rv=%0b rpc=%0h data=%0h cs=%0d sel=%0d",
                             cyc, wr_cp0op, redirect_valid, redirect_pc, wr_data, wr_cs, wr_sel,
                             me.cyc, me.op, me.rv, me.rpc, me.data, me.cs, me.sel);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event cyc=%0d got op=0 rv=0 exp op=%0h rv=%0b at cyc=%0d",
                     cyc, exp_q[0].op, exp_q[0].rv, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        ie_v = 1'b1;
        exl_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        idle(2);
        step(1'b1, 3'b010, 30'h40, 5'd12, 3'd0, 32'h0000_0001, '0);
        idle(1);
        step(1'b1, 3'b011, 30'h100, '0, '0, '0, '0);
        idle(6);
        step(1'b1, 3'b100, 30'h104, '0, '0, '0, 32'h0000_0408);
        idle(5);
        irq_v[3] = 1'b1;
        nops(6, 30'h200);
        idle(6);
        irq_v[3] = 1'b0;
        idle(2);
        exl_v = 1'b1;
        irq_v[3] = 1'b1;
        nops(8, 30'h200);
        exl_v = 1'b0;
        step(1'b1, 3'b011, 30'h300, '0, '0, '0, '0);
        nops(8, 30'h304);
        irq_v = '0;
        idle(3);
        irq_v[0] = 1'b1;
        nops(6, 30'h3FFF_FFFF);
        idle(6);
        irq_v = '0;
        idle(3);
        irq_v = 6'b100010;
        nops(14, 30'h240);
        step(1'b1, 3'b011, 30'h3FFF_FFFF, '0, '0, '0, '0);
        idle(6);
        step(1'b1, 3'b011, 30'h500, '0, '0, '0, '0);
        do_reset(2);
        idle(6);
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 15) == 0) irq_v[$urandom_range(0, NUM_IRQ - 1)] ^= 1'b1;
            ie_v = $urandom_range(0, 3) != 0;
            exl_v = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
            else step($urandom_range(0, 3) != 0, pick_op(), 30'($urandom()), 5'($urandom()),
                      3'($urandom()), 32'($urandom()), 32'($urandom()));
        end
        idle(DRAIN + 6);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue got=%0d pending events exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
